// File: rtl/ras_pkg.sv
// Shared types and constants for the return-address-stack controller.
// Used by ras_out_slot and ras_ctrl.
package ras_pkg;

   localparam int unsigned RAS_DW   = 32;
   localparam int unsigned ILEN_STD = 4;
   localparam int unsigned ILEN_RVC = 2;

   // Encoded as {is_call, is_ret}
   typedef enum logic [1:0] {
      RAS_NONE     = 2'b00,
      RAS_POP      = 2'b01,
      RAS_PUSH     = 2'b10,
      RAS_PUSH_POP = 2'b11
   } ras_op_e;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_st_e;

   typedef struct packed {
      logic [RAS_DW-1:0] target;
      logic              hit;
   } ras_pred_t;

endpackage

// File: rtl/ras_out_slot.sv
// One-entry valid/ready output register holding a return prediction.
// Flush empties the slot and has priority over a new load.
module ras_out_slot
   import ras_pkg::*;
#(
   parameter type pred_t = ras_pred_t
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  i_flush,
   input  logic  i_load,
   input  pred_t i_data,
   output logic  o_ready,
   output logic  o_valid,
   input  logic  i_ready,
   output pred_t o_data
);

   slot_st_e state_q;
   pred_t    data_q;

   // Slot state machine; the payload only changes on a load
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
      end else if (i_flush) begin
         state_q <= SLOT_EMPTY;
      end else if (i_load) begin
         state_q <= SLOT_FULL;
         data_q  <= i_data;
      end else if (state_q == SLOT_FULL && i_ready) begin
         state_q <= SLOT_EMPTY;
      end
   end

   assign o_valid = (state_q == SLOT_FULL);
   assign o_ready = (state_q == SLOT_EMPTY) | i_ready;
   assign o_data  = data_q;

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: decode -> call stack strobes + prediction.
// Optional statistics counters enabled with RAS_STATS_EN.
module ras_ctrl
   import ras_pkg::*;
#(
   parameter int unsigned DW    = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [DW-1:0]    i_pc,
   input  logic             i_is_call,
   input  logic             i_is_ret,
   input  logic             i_is_rvc,
   input  logic             i_flush,
   output logic             o_push_en,
   output logic [DW-1:0]    o_push_data,
   input  logic             i_stk_full,
   output logic             o_pop_en,
   input  logic [DW-1:0]    i_pop_data,
   input  logic             i_stk_empty,
   output logic             o_pred_valid,
   input  logic             i_pred_ready,
   output logic [DW-1:0]    o_pred_target,
   output logic             o_pred_hit,
   output logic             o_ovf,
   output logic [CNT_W-1:0] o_stat_call,
   output logic [CNT_W-1:0] o_stat_ret,
   output logic [CNT_W-1:0] o_stat_unf,
   output logic [CNT_W-1:0] o_stat_ovf
);

   typedef struct packed {
      logic [DW-1:0] target;
      logic          hit;
   } pred_t;

   logic          slot_rdy;
   logic          accept;
   logic [DW-1:0] ra;
   ras_op_e       op;
   logic          push;
   logic          pop;
   logic          load;
   pred_t         pred_d;
   pred_t         pred_q;

   // Nothing is accepted while reset is held so the strobes stay quiet
   assign accept = i_valid & o_ready & ~i_flush & ~rst;
   assign o_ready = slot_rdy;
   assign ra = i_pc + (i_is_rvc ? DW'(ILEN_RVC) : DW'(ILEN_STD));
   assign op = ras_op_e'({i_is_call, i_is_ret});

   // Decode the accepted instruction into stack strobes and the next prediction
   always_comb begin
      push   = 1'b0;
      pop    = 1'b0;
      load   = 1'b0;
      pred_d = '0;
      if (accept) begin
         unique case (op)
            RAS_PUSH: begin
               push = 1'b1;
            end
            RAS_POP: begin
               pop  = ~i_stk_empty;
               load = 1'b1;
            end
            RAS_PUSH_POP: begin
               push = 1'b1;
               pop  = ~i_stk_empty;
               load = 1'b1;
            end
            default: ;
         endcase
         if (i_stk_empty) begin
            pred_d.target = ra;
            pred_d.hit    = 1'b0;
         end else begin
            pred_d.target = i_pop_data;
            pred_d.hit    = 1'b1;
         end
      end
   end

   assign o_push_en   = push;
   assign o_pop_en    = pop;
   assign o_push_data = ra;
   assign o_ovf       = push & ~pop & i_stk_full;

   ras_out_slot #(
      .pred_t (pred_t)
   ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_flush (i_flush),
      .i_load  (load),
      .i_data  (pred_d),
      .o_ready (slot_rdy),
      .o_valid (o_pred_valid),
      .i_ready (i_pred_ready),
      .o_data  (pred_q)
   );

   assign o_pred_target = pred_q.target;
   assign o_pred_hit    = pred_q.hit;

`ifdef RAS_STATS_EN
   logic [CNT_W-1:0] call_q, call_d;
   logic [CNT_W-1:0] ret_q, ret_d;
   logic [CNT_W-1:0] unf_q, unf_d;
   logic [CNT_W-1:0] ovf_q, ovf_d;

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v,
      input logic             en
   );
      if (en && v != '1) return v + 1'b1;
      return v;
   endfunction

   // Saturating event counters
   always_comb begin
      call_d = sat_inc(call_q, accept & i_is_call);
      ret_d  = sat_inc(ret_q, accept & i_is_ret);
      unf_d  = sat_inc(unf_q, accept & i_is_ret & i_stk_empty);
      ovf_d  = sat_inc(ovf_q, o_ovf);
   end

   // Counter registers, cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         call_q <= '0;
         ret_q  <= '0;
         unf_q  <= '0;
         ovf_q  <= '0;
      end else begin
         call_q <= call_d;
         ret_q  <= ret_d;
         unf_q  <= unf_d;
         ovf_q  <= ovf_d;
      end
   end

   assign o_stat_call = call_q;
   assign o_stat_ret  = ret_q;
   assign o_stat_unf  = unf_q;
   assign o_stat_ovf  = ovf_q;
`else
   assign o_stat_call = '0;
   assign o_stat_ret  = '0;
   assign o_stat_unf  = '0;
   assign o_stat_ovf  = '0;
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed testbench for ras_ctrl: vector table plus multi-cycle sequences.
// Statistics checks follow RAS_STATS_EN.
module tb_ras_ctrl;

   localparam int DW = 32;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_valid;
   logic          o_ready;
   logic [DW-1:0] i_pc;
   logic          i_is_call;
   logic          i_is_ret;
   logic          i_is_rvc;
   logic          i_flush;
   logic          o_push_en;
   logic [DW-1:0] o_push_data;
   logic          i_stk_full;
   logic          o_pop_en;
   logic [DW-1:0] i_pop_data;
   logic          i_stk_empty;
   logic          o_pred_valid;
   logic          i_pred_ready;
   logic [DW-1:0] o_pred_target;
   logic          o_pred_hit;
   logic          o_ovf;
   logic [CW-1:0] o_stat_call;
   logic [CW-1:0] o_stat_ret;
   logic [CW-1:0] o_stat_unf;
   logic [CW-1:0] o_stat_ovf;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ras_ctrl #(.DW(DW), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .i_pc          (i_pc),
      .i_is_call     (i_is_call),
      .i_is_ret      (i_is_ret),
      .i_is_rvc      (i_is_rvc),
      .i_flush       (i_flush),
      .o_push_en     (o_push_en),
      .o_push_data   (o_push_data),
      .i_stk_full    (i_stk_full),
      .o_pop_en      (o_pop_en),
      .i_pop_data    (i_pop_data),
      .i_stk_empty   (i_stk_empty),
      .o_pred_valid  (o_pred_valid),
      .i_pred_ready  (i_pred_ready),
      .o_pred_target (o_pred_target),
      .o_pred_hit    (o_pred_hit),
      .o_ovf         (o_ovf),
      .o_stat_call   (o_stat_call),
      .o_stat_ret    (o_stat_ret),
      .o_stat_unf    (o_stat_unf),
      .o_stat_ovf    (o_stat_ovf)
   );

   typedef struct {
      string       name;
      logic        valid;
      logic [31:0] pc;
      logic        call;
      logic        ret;
      logic        rvc;
      logic        flush;
      logic        full;
      logic        empty;
      logic [31:0] top;
      logic        prdy;
      logic        e_ready;
      logic        e_push;
      logic [31:0] e_pdata;
      logic        e_pop;
      logic        e_ovf;
      logic        e_pv;
      logic [31:0] e_tgt;
      logic        e_hit;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc,
                        input logic c, input logic r, input logic rvc,
                        input logic fl, input logic full,
                        input logic emp, input logic [31:0] top,
                        input logic prdy);
      i_valid      = v;
      i_pc         = pc;
      i_is_call    = c;
      i_is_ret     = r;
      i_is_rvc     = rvc;
      i_flush      = fl;
      i_stk_full   = full;
      i_stk_empty  = emp;
      i_pop_data   = top;
      i_pred_ready = prdy;
   endtask

   initial begin
      //        name    v  pc            c  r  rv fl fu em top      rdy
      //        erdy epush epdata      epop eovf epv etgt    ehit
      vecs[0] = '{"call",  1, 32'h1000, 1, 0, 0, 0, 0, 1, 32'h0, 1,
                  1, 1, 32'h1004, 0, 0, 0, 32'h0, 0};
      vecs[1] = '{"ret_hit", 1, 32'h1010, 0, 1, 0, 0, 0, 0, 32'h1004, 1,
                  1, 0, 32'h1014, 1, 0, 1, 32'h1004, 1};
      vecs[2] = '{"ret_unf", 1, 32'h2000, 0, 1, 1, 0, 0, 1, 32'h0, 1,
                  1, 0, 32'h2002, 0, 0, 1, 32'h2002, 0};
      vecs[3] = '{"none",  1, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 1,
                  1, 0, 32'h4, 0, 0, 0, 32'h2002, 0};
      vecs[4] = '{"ovf",   1, 32'h1100, 1, 0, 0, 0, 1, 0, 32'h0, 1,
                  1, 1, 32'h1104, 0, 1, 0, 32'h2002, 0};
      vecs[5] = '{"corout", 1, 32'h3000, 1, 1, 0, 0, 1, 0, 32'h1004, 1,
                  1, 1, 32'h3004, 1, 0, 1, 32'h1004, 1};
      vecs[6] = '{"idle",  0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 1,
                  1, 0, 32'h4, 0, 0, 0, 32'h1004, 1};
      vecs[7] = '{"wrap",  1, 32'hFFFF_FFFE, 1, 0, 1, 0, 0, 0, 32'h0, 1,
                  1, 1, 32'h0, 0, 0, 0, 32'h1004, 1};
      vecs[8] = '{"flush", 1, 32'h5000, 0, 1, 0, 1, 0, 0, 32'h7777, 1,
                  1, 0, 32'h5004, 0, 0, 0, 32'h1004, 1};

      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pv", 32'(o_pred_valid), 0);
      chk("rst_tgt", o_pred_target, 0);
      chk("rst_hit", 32'(o_pred_hit), 0);
      chk("rst_ovf", 32'(o_ovf), 0);
      chk("rst_push", 32'(o_push_en), 0);
      chk("rst_pop", 32'(o_pop_en), 0);
      chk("rst_rdy", 32'(o_ready), 1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].valid, vecs[i].pc, vecs[i].call, vecs[i].ret,
               vecs[i].rvc, vecs[i].flush, vecs[i].full, vecs[i].empty,
               vecs[i].top, vecs[i].prdy);
         #1;
         chk({vecs[i].name, "_rdy"}, 32'(o_ready), 32'(vecs[i].e_ready));
         chk({vecs[i].name, "_push"}, 32'(o_push_en), 32'(vecs[i].e_push));
         chk({vecs[i].name, "_pdata"}, o_push_data, vecs[i].e_pdata);
         chk({vecs[i].name, "_pop"}, 32'(o_pop_en), 32'(vecs[i].e_pop));
         chk({vecs[i].name, "_ovf"}, 32'(o_ovf), 32'(vecs[i].e_ovf));
         @(posedge clk);
         #1;
         chk({vecs[i].name, "_pv"}, 32'(o_pred_valid), 32'(vecs[i].e_pv));
         chk({vecs[i].name, "_tgt"}, o_pred_target, vecs[i].e_tgt);
         chk({vecs[i].name, "_hit"}, 32'(o_pred_hit), 32'(vecs[i].e_hit));
         @(negedge clk);
      end

      // Stall: prediction held while fetch is not ready
      drive(1, 32'h4000, 0, 1, 0, 0, 0, 1, 0, 0);
      @(posedge clk);
      #1;
      chk("stl_pv0", 32'(o_pred_valid), 1);
      chk("stl_tgt0", o_pred_target, 32'h4004);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(1, 32'h5000, 0, 1, 0, 0, 0, 0, 32'hAAAA, 0);
         #1;
         chk("stl_rdy", 32'(o_ready), 0);
         chk("stl_pop", 32'(o_pop_en), 0);
         @(posedge clk);
         #1;
         chk("stl_pv", 32'(o_pred_valid), 1);
         chk("stl_tgt", o_pred_target, 32'h4004);
         chk("stl_hit", 32'(o_pred_hit), 0);
      end
      @(negedge clk);
      i_pred_ready = 1'b1;
      #1;
      chk("rel_rdy", 32'(o_ready), 1);
      chk("rel_pop", 32'(o_pop_en), 1);
      @(posedge clk);
      #1;
      chk("rel_pv", 32'(o_pred_valid), 1);
      chk("rel_tgt", o_pred_target, 32'hAAAA);
      chk("rel_hit", 32'(o_pred_hit), 1);

      // Flush while a prediction is held
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("hold_pv", 32'(o_pred_valid), 1);
      @(negedge clk);
      drive(1, 32'h6000, 1, 1, 0, 1, 0, 0, 32'hBBBB, 0);
      #1;
      chk("fl_push", 32'(o_push_en), 0);
      chk("fl_pop", 32'(o_pop_en), 0);
      @(posedge clk);
      #1;
      chk("fl_pv", 32'(o_pred_valid), 0);

      // Reset in the middle of a stall
      @(negedge clk);
      drive(1, 32'h6000, 0, 1, 0, 0, 0, 1, 0, 0);
      @(posedge clk);
      #1;
      chk("pre_rst_pv", 32'(o_pred_valid), 1);
      chk("pre_rst_tgt", o_pred_target, 32'h6004);
      @(negedge clk);
      rst = 1'b1;
      drive(1, 32'h7000, 1, 0, 0, 0, 1, 0, 0, 0);
      #1;
      chk("mrst_push", 32'(o_push_en), 0);
      chk("mrst_ovf", 32'(o_ovf), 0);
      @(posedge clk);
      #1;
      chk("mrst_pv", 32'(o_pred_valid), 0);
      chk("mrst_tgt", o_pred_target, 0);
      chk("mrst_hit", 32'(o_pred_hit), 0);
      chk("mrst_rdy", 32'(o_ready), 1);
`ifdef RAS_STATS_EN
      chk("stat_unf_clr", 32'(o_stat_unf), 0);
`else
      chk("stat_call0", 32'(o_stat_call), 0);
      chk("stat_ret0", 32'(o_stat_ret), 0);
      chk("stat_unf0", 32'(o_stat_unf), 0);
      chk("stat_ovf0", 32'(o_stat_ovf), 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      drive(1, 32'h2000, 0, 1, 1, 0, 0, 1, 0, 1);
      @(posedge clk);
      #1;
      chk("post_tgt", o_pred_target, 32'h2002);
`ifdef RAS_STATS_EN
      chk("stat_unf1", 32'(o_stat_unf), 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
